// File: rtl/onehot_dispatch_pkg.sv
// Shared types and defaults for the one-hot dispatcher.
// Holds the FSM state encoding and the default line count / hold limit.
// No logic; pure declarations.
package onehot_dispatch_pkg;

  // Dispatcher is either waiting for a request or holding a line.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DISPATCH_N       = 8;
  localparam int DISPATCH_TIMEOUT = 16;

endpackage

// File: rtl/bin2onehot.sv
// Binary index to one-hot decoder with an enable gate.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs directly.
module bin2onehot #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx_i,
  input  logic         en_i,
  output logic [N-1:0] onehot_o
);

  // Raise exactly the line matching idx_i; indices >= N decode to all zeros.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (idx_i == W'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_dispatch.sv
// Accepts a binary index and holds the matching one-hot line until ack or timeout.
// Latency: line driven one cycle after acceptance; Done/Timeout/Err one cycle after the deciding edge.
// Backpressure: In_ready is low for the whole hold; upstream must keep its request pending.
module onehot_dispatch import onehot_dispatch_pkg::*; #(
  parameter int N       = DISPATCH_N,
  parameter int W       = $clog2(N),
  parameter int TIMEOUT = DISPATCH_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] In_idx,
  input  logic         In_valid,
  output logic         In_ready,
  output logic [N-1:0] Out,
  output logic         Out_valid,
  input  logic [N-1:0] Ack,
  output logic         Done,
  output logic         Timeout,
  output logic         Err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last cycle of the hold window; the counter starts at zero on the first BUSY cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  // Index range limit, one bit wider so that N itself is representable.
  localparam logic [W:0]    N_LIM    = (W + 1)'(N);

  state_e        state_q, state_d;
  logic [W-1:0]  idx_q,   idx_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          done_q,  done_d;
  logic          tmo_q,   tmo_d;
  logic          err_q,   err_d;

  logic          busy;
  logic          in_range;
  logic          ack_hit;
  logic [N-1:0]  line;

  assign busy     = (state_q == BUSY);
  assign in_range = ({1'b0, In_idx} < N_LIM);

  bin2onehot #(
    .N (N),
    .W (W)
  ) u_dec (
    .idx_i    (idx_q),
    .en_i     (busy),
    .onehot_o (line)
  );

  // Only the captured line's acknowledge matters; line is zero outside BUSY.
  assign ack_hit = |(Ack & line);

  // Next-state: accept/reject in IDLE, ack beats timeout in BUSY.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (In_valid) begin
          if (in_range) begin
            idx_d   = In_idx;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (ack_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, hold counter and completion pulses; reset drops the line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign In_ready  = (state_q == IDLE);
  assign Out       = line;
  assign Out_valid = |line;
  assign Done      = done_q;
  assign Timeout   = tmo_q;
  assign Err       = err_q;

endmodule

// File: doc/onehot_dispatch.md
# onehot_dispatch

Sequential binary-to-one-hot dispatcher, the decode side of the priority encoder's index/valid output. It accepts a binary index over a valid/ready handshake and drives the matching one-hot line. The line is held until that line's acknowledge arrives or a timeout expires, and one completion pulse is reported. It sits downstream of priority encoding in request/service paths such as interrupt dispatch, lane select and channel wake-up.

## Interface
- N, default 8: number of one-hot lines, minimum 2.
- W, default $clog2(N): index width.
- TIMEOUT, default 16: maximum number of cycles a line is held without acknowledge, minimum 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- In_idx  in  W  binary index of the line to drive.
- In_valid  in  1  In_idx is valid.
- In_ready  out  1  block can accept; combinational, equal to (state == IDLE).
- Out  out  N  one-hot drive; all zeros when idle.
- Out_valid  out  1  Out is driving a line; equals |Out.
- Ack  in  N  per-line acknowledge; only the bit at the captured index is observed.
- Done  out  1  one-cycle pulse: the line was acknowledged.
- Timeout  out  1  one-cycle pulse: the line expired without acknowledge.
- Err  out  1  one-cycle pulse: an out-of-range index (>= N) was accepted and dropped.

## Operation
- States are IDLE and BUSY. Registers: state, idx_q (W bits), cnt ($clog2(TIMEOUT+1) bits), and registered pulses Done, Timeout, Err.
- IDLE:
  - In_ready = 1.
  - On In_valid with In_idx < N: capture idx_q, set cnt = 0, go to BUSY.
  - On In_valid with In_idx >= N: stay in IDLE and pulse Err on the next cycle.
- BUSY:
  - Out = 1 << idx_q and In_ready = 0. In_valid is ignored; the upstream holds its request.
  - Priority order each cycle:
    - If Ack[idx_q] = 1: go to IDLE and pulse Done.
    - Else if cnt == TIMEOUT-1: go to IDLE and pulse Timeout.
    - Else: cnt increments by 1.
- Ack and the final timeout cycle in the same cycle: Ack wins, so Done = 1 and Timeout = 0.
- Ack bits other than idx_q are ignored at all times. Ack while in IDLE is ignored.
- Done, Timeout and Err are mutually exclusive and never last longer than one cycle.
- Back-to-back transfers: the IDLE cycle that carries the Done or Timeout pulse can accept a new request, so there are no dead cycles.
- Out is never multi-hot. Out is zero in every IDLE cycle.

## Timing
- Reset values, applied immediately while rst_n = 0:
  - state = IDLE.
  - Out = 0, Out_valid = 0.
  - Done = 0, Timeout = 0, Err = 0.
  - cnt = 0, idx_q = 0.
  - In_ready = 1.
- Reset in the middle of BUSY: Out drops asynchronously, the transfer is lost, and neither Done nor Timeout is produced.
- Request accepted at edge t0: Out is valid from cycle t0+1.
- Ack sampled high in BUSY cycle k: in cycle k+1, Out = 0 and Done = 1.
- No Ack: Out is high for exactly TIMEOUT cycles (t0+1 through t0+TIMEOUT). Timeout = 1 in cycle t0+TIMEOUT+1.
- Err asserts in the cycle after the out-of-range request is accepted.

## Structure
- Package onehot_dispatch_pkg holds:
  - the state_e enum (IDLE, BUSY);
  - default constants DISPATCH_N = 8 and DISPATCH_TIMEOUT = 16.
- Sub-module bin2onehot, parameterized by N: combinational decode of idx_q, gated by state == BUSY. It is reused elsewhere.
- The FSM, counter and pulse registers live in a single always_ff with the asynchronous active-low reset.

## Test plan
- Reset: hold rst_n = 0 with random inputs → Out = 0, Out_valid = 0, Done/Timeout/Err = 0, In_ready = 1.
- Acknowledge path: In_idx = 5 with In_valid in cycle 0 → Out = 8'b0010_0000 from cycle 1 and In_ready = 0. Drive Ack = 8'b0010_0000 in cycle 3 → cycle 4 has Out = 0, Done = 1, In_ready = 1.
- Timeout path, TIMEOUT = 4: In_idx = 2, with Ack = 8'b0000_1000 held (wrong line) → Out = 8'b0000_0100 for cycles 1–4. Cycle 5 has Out = 0, Timeout = 1, Done = 0.
- Simultaneous events, TIMEOUT = 4: Ack[2] arrives in cycle 4 → Done = 1 and Timeout = 0. Separately, a new request (In_idx = 0) in the Done cycle is accepted → Out = 8'b0000_0001 in the next cycle.
- Range error, N = 6: In_idx = 7 with In_valid → Err = 1 for one cycle, Out stays 0, In_ready stays 1.
- Reset mid-transfer: deassert rst_n while in BUSY → Out goes to 0 asynchronously, and after release Done never asserts for that transfer.
